ps2_keyboard_display: RTL and testbench



---
 rtl/ps2_kbd_pkg.sv | 21 ++
 rtl/seg8_scan.sv | 55 +++++
 rtl/ps2_keyboard_display.sv | 179 +++++++++++++++++
 tb/tb_ps2_keyboard_display.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared types and display constants for the PS/2 keyboard display.
// Optional HISTORY_EN shows the three previous bytes on digits 7:2.
package ps2_kbd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } rx_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs, bit 0 = CA ... bit 6 = CG; entry n shows hex n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg8_scan.sv
// Eight-digit multiplexed seven-segment scanner with hex decode.
// Divider tick advances the digit slot; an/seg are registered together.
module seg8_scan
    import ps2_kbd_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0][3:0] nib_i,
    input  logic [7:0]      blank_i,
    output logic [7:0]      an_o,
    output logic [6:0]      seg_o
);

    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DW-1:0] DLAST = DW'(REFRESH_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          tick;

    assign tick = (div_q == DLAST);

    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
        idx_d = tick ? idx_q + 3'd1 : idx_q;
        an_d  = ~(8'b1 << idx_d);
        seg_d = HEX_SEG[nib_i[idx_d]];
        if (blank_i[idx_d]) begin
            an_d  = 8'hFF;
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            idx_q <= '0;
            an_q  <= 8'hFE;
            seg_q <= HEX_SEG[0];
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;

endmodule

// File: rtl/ps2_keyboard_display.sv
// PS/2 scan-code receiver showing the latest byte in hex on 8 digits.
// Define HISTORY_EN to display the three previous bytes on digits 7:2.
module ps2_keyboard_display
    import ps2_kbd_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT     = 200000,
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       inhibit,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       busy,
    output logic [7:0] an,
    output logic [6:0] seg
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FLAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          sclk, sdat;
    logic          filt_q, filt_d, filt_prev_q;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
        end
    end

    assign sclk = clk_sync_q[1];
    assign sdat = dat_sync_q[1];

    // Any sample matching the current level restarts the run count.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sclk != filt_q) begin
            if (fcnt_q == FLAST) begin
                filt_d = sclk;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
        end else begin
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            fcnt_q      <= fcnt_d;
        end
    end

    assign fall = filt_prev_q & ~filt_q;

    rx_state_e     state_q;
    logic [3:0]    bitcnt_q;
    logic [8:0]    sh_q;
    logic [TW-1:0] timer_q;
    logic [7:0]    data_q;
    logic          valid_q, perr_q, busy_q;
    logic          last_bit, accept;

    assign last_bit = !inhibit && state_q == SHIFT
                      && fall && bitcnt_q == 4'd9;
    assign accept   = last_bit && sdat && (^sh_q);

    // The stop-bit edge judges the frame; CHECK is the one-cycle exit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            sh_q     <= '0;
            timer_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            if (inhibit) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                timer_q <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (fall && !sdat) begin
                            state_q  <= SHIFT;
                            bitcnt_q <= '0;
                            timer_q  <= '0;
                            busy_q   <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (fall) begin
                            timer_q  <= '0;
                            bitcnt_q <= bitcnt_q + 4'd1;
                            if (last_bit) begin
                                state_q <= CHECK;
                                busy_q  <= 1'b0;
                                valid_q <= accept;
                                perr_q  <= !accept;
                                if (accept) data_q <= sh_q[7:0];
                            end else begin
                                sh_q <= {sdat, sh_q[8:1]};
                            end
                        end else if (timer_q == TLAST) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    CHECK: state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign busy       = busy_q;

    logic [7:0][3:0] nib;
    logic [7:0]      blank;

`ifdef HISTORY_EN
    logic [2:0][7:0] hist_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
        end else if (accept) begin
            hist_q <= {hist_q[1:0], data_q};
        end
    end

    assign nib   = {hist_q, data_q};
    assign blank = 8'h00;
`else
    assign nib   = {24'h0, data_q};
    assign blank = 8'hFC;
`endif

    seg8_scan #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_scan (
        .clk    (clk),
        .reset  (reset),
        .nib_i  (nib),
        .blank_i(blank),
        .an_o   (an),
        .seg_o  (seg)
    );

endmodule

// File: tb/tb_ps2_keyboard_display.sv
// Randomised PS/2 frame bench with a byte-level display/receiver model.
// Define HISTORY_EN to check the history digits as well.
module tb_ps2_keyboard_display;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       inhibit;
    logic [7:0] data;
    logic       valid;
    logic       parity_err;
    logic       busy;
    logic [7:0] an;
    logic [6:0] seg;

    int errors = 0;
    int checks = 0;
    int vcnt = 0;
    int pcnt = 0;
    int exp_v = 0;
    int exp_p = 0;
    logic [7:0] mb [4];
    logic mid_busy;
    logic prev_pulse = 1'b0;

    always #5 clk = ~clk;

    ps2_keyboard_display #(
        .FILTER_LEN (4),
        .TIMEOUT    (2000),
        .REFRESH_DIV(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .inhibit   (inhibit),
        .data      (data),
        .valid     (valid),
        .parity_err(parity_err),
        .busy      (busy),
        .an        (an),
        .seg       (seg)
    );

    // Pulse monitor: counts pulses, checks width and busy at the pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid) vcnt++;
            if (parity_err) pcnt++;
            if (valid || parity_err) begin
                checks++;
                if (busy !== 1'b0 || prev_pulse || (valid && parity_err)) begin
                    errors++;
                    $display("FAIL pulse_shape: busy=%b prev=%b v=%b p=%b, required busy=0 single pulse",
                             busy, prev_pulse, valid, parity_err);
                end
            end
            prev_pulse = valid | parity_err;
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic digit_blank(input int d);
`ifdef HISTORY_EN
        return 1'b0;
`else
        return d >= 2;
`endif
    endfunction

    function automatic logic [6:0] exp_seg(input int d);
        logic [7:0] b;
        if (digit_blank(d)) return 7'h7F;
        b = mb[d / 2];
        return glyph((d % 2) ? b[7:4] : b[3:0]);
    endfunction

    function automatic logic [7:0] exp_an(input int d);
        if (digit_blank(d)) return 8'hFF;
        return ~(8'd1 << d);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        cyc(100);
        ps2_clk = 1'b0;
        cyc(200);
        ps2_clk = 1'b1;
        cyc(100);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            send_bit(fr[i]);
            if (i == 5) mid_busy = busy;
        end
        ps2_data = 1'b1;
        cyc(20);
    endtask

    task automatic model_frame(input logic [7:0] b, input bit bad);
        if (bad) begin
            exp_p++;
        end else begin
            for (int i = 3; i > 0; i--) mb[i] = mb[i-1];
            mb[0] = b;
            exp_v++;
        end
    endtask

    task automatic check_rx(input string name);
        checks++;
        if (vcnt !== exp_v || pcnt !== exp_p) begin
            errors++;
            $display("FAIL %s_counts: valid=%0d perr=%0d, required %0d %0d",
                     name, vcnt, pcnt, exp_v, exp_p);
        end
        checks++;
        if (data !== mb[0] || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_data: data=%h busy=%b, required %h 0",
                     name, data, busy, mb[0]);
        end
    endtask

    task automatic check_digit(input int d, input string name);
        int n = 0;
        while (an !== ~(8'd1 << d) && n < 300) begin
            cyc(1);
            n++;
        end
        checks++;
        if (n >= 300 || seg !== exp_seg(d)) begin
            errors++;
            $display("FAIL %s: an=%h seg=%b, required digit %0d seg=%b",
                     name, an, seg, d, exp_seg(d));
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cyc(5);
        @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if (data !== 8'h00 || valid !== 1'b0 || parity_err !== 1'b0
            || busy !== 1'b0 || an !== 8'hFE || seg !== 7'b1000000) begin
            errors++;
            $display("FAIL reset: data=%h v=%b p=%b busy=%b an=%h seg=%b, required 00 0 0 0 fe 1000000",
                     data, valid, parity_err, busy, an, seg);
        end
    endtask

    // Must run right after test_reset: slot = edges since release / 16.
    task automatic test_scan_step;
        int d;
        for (int k = 1; k <= 128; k++) begin
            cyc(1);
            d = (k / 16) % 8;
            checks++;
            if (an !== exp_an(d) || seg !== exp_seg(d)) begin
                errors++;
                $display("FAIL scan_step k=%0d: an=%h seg=%b, required %h %b",
                         k, an, seg, exp_an(d), exp_seg(d));
            end
        end
    endtask

    task automatic test_frame_1c;
        send_frame(8'h1C, 1'b0);
        model_frame(8'h1C, 1'b0);
        check_rx("frame_1c");
        checks++;
        if (mid_busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_1c_busy: busy=%b, required 1", mid_busy);
        end
        check_digit(0, "digit0_C");
        check_digit(1, "digit1_1");
    endtask

    task automatic test_parity_err;
        send_frame(8'h1C, 1'b1);
        model_frame(8'h1C, 1'b1);
        check_rx("parity_err");
    endtask

    task automatic test_glitch;
        logic seen = 1'b0;
        ps2_clk = 1'b0;
        cyc(2);
        ps2_clk = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            seen |= busy;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy: busy seen=%b, required 0", seen);
        end
        check_rx("glitch");
    endtask

    task automatic test_timeout;
        int n = 0;
        logic [4:0] bits;
        bits = {4'($urandom), 1'b0};
        for (int i = 0; i < 5; i++) send_bit(bits[i]);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_busy: busy=%b, required 1", busy);
        end
        while (busy === 1'b1 && n < 3000) begin
            cyc(1);
            n++;
        end
        checks++;
        if (300 + n < 1995 || 300 + n > 2020) begin
            errors++;
            $display("FAIL timeout_len: busy fell %0d cycles after last edge, required about 2007",
                     300 + n);
        end
        check_rx("timeout");
        send_frame(8'hF0, 1'b0);
        model_frame(8'hF0, 1'b0);
        check_rx("after_timeout");
    endtask

    task automatic test_inhibit;
        logic [10:0] fr;
        logic seen = 1'b0;
        logic [7:0] b;
        b = 8'($urandom);
        fr = {1'b1, ~^b, b, 1'b0};
        for (int i = 0; i < 4; i++) send_bit(fr[i]);
        inhibit = 1'b1;
        cyc(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL inhibit_busy: busy=%b, required 0", busy);
        end
        for (int i = 4; i < 11; i++) begin
            send_bit(fr[i]);
            seen |= busy;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL inhibit_hold: busy seen=%b, required 0", seen);
        end
        cyc(20);
        inhibit = 1'b0;
        cyc(20);
        check_rx("inhibit");
    endtask

    task automatic test_random;
        logic [7:0] b;
        bit bad;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            bad = ($urandom_range(2) == 0);
            send_frame(b, bad);
            model_frame(b, bad);
            check_rx("random");
        end
    endtask

    task automatic test_history;
        send_frame(8'h11, 1'b0);
        model_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b0);
        model_frame(8'h22, 1'b0);
        check_rx("history");
`ifdef HISTORY_EN
        check_digit(2, "hist_digit2");
        check_digit(3, "hist_digit3");
`endif
    endtask

    task automatic test_display_scan;
        int d;
        for (int k = 0; k < 160; k++) begin
            cyc(1);
            d = -1;
            for (int j = 0; j < 8; j++)
                if (an === ~(8'd1 << j)) d = j;
            checks++;
            if (an === 8'hFF) begin
                if (seg !== 7'h7F || !digit_blank(2)) begin
                    errors++;
                    $display("FAIL scan_blank: seg=%b, required 1111111 and blanking enabled",
                             seg);
                end
            end else if (d < 0 || an !== exp_an(d) || seg !== exp_seg(d)) begin
                errors++;
                $display("FAIL scan: an=%h seg=%b, required one-hot-low an and model glyph",
                         an, seg);
            end
        end
    endtask

    task automatic test_reset_midframe;
        for (int i = 0; i < 4; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) mb[i] = 8'h00;
        checks++;
        if (busy !== 1'b0 || data !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: busy=%b data=%h, required 0 00", busy, data);
        end
        cyc(5);
        reset = 1'b0;
        for (int i = 4; i < 11; i++) send_bit(1'b1);
        cyc(20);
        check_rx("reset_mid");
        send_frame(8'h5A, 1'b0);
        model_frame(8'h5A, 1'b0);
        check_rx("after_reset");
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mb[i] = 8'h00;
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        inhibit  = 1'b0;
        mid_busy = 1'b0;
        test_reset;
        test_scan_step;
        test_frame_1c;
        test_parity_err;
        test_glitch;
        test_timeout;
        test_inhibit;
        test_random;
        test_history;
        test_display_scan;
        test_reset_midframe;
        test_display_scan;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
